// File: rtl/i2c_reg_sequencer_if.sv
// Command/response and byte-master handshake bundle for the I2C register sequencer.
// The slave modport is the sequencer's view; the master modport is the upstream and byte-master view.
interface i2c_reg_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic       m_start;
  logic       m_send;
  logic       m_receive;
  logic [7:0] m_datasend;
  logic       m_ready;
  logic       m_sended;
  logic       m_received;
  logic [7:0] m_datareceive;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
    input  m_ready, m_sended, m_received, m_datareceive,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output m_start, m_send, m_receive, m_datasend
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
    output m_ready, m_sended, m_received, m_datareceive,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    input  m_start, m_send, m_receive, m_datasend
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write command into the byte master's start/send/receive sequence,
// reporting read data and an error flag (slave NACK or master timeout).
module i2c_reg_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_500_000
) (
  input  logic                      clk,
  input  logic                      reset,
  i2c_reg_sequencer_if.slave        bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR_W, XFER_ADDR, XFER_REG, XFER_DATA,
    XFER_ADDR_R, XFER_RD, WAIT_STOP, DONE
  } state_t;

  state_t      state_reg;
  logic [23:0] timer_reg;
  logic        sended_prev_reg;
  logic        received_prev_reg;
  logic        rw_reg;
  logic [6:0]  dev_reg;
  logic [7:0]  regaddr_reg;
  logic [7:0]  wdata_reg;

  logic        cmd_ready_reg;
  logic        rsp_valid_reg;
  logic        rsp_err_reg;
  logic [7:0]  rsp_rdata_reg;
  logic        m_start_reg;
  logic        m_send_reg;
  logic        m_receive_reg;
  logic [7:0]  m_datasend_reg;

  logic        sended_rise;
  logic        sended_fall;
  logic        received_rise;
  logic        accept;
  logic        timeout;
  logic        nack;
  logic        fail;

  assign sended_rise   = bus.m_sended & ~sended_prev_reg;
  assign sended_fall   = ~bus.m_sended & sended_prev_reg;
  assign received_rise = bus.m_received & ~received_prev_reg;
  assign accept        = bus.cmd_valid & cmd_ready_reg & bus.m_ready;

  // The master returning to idle before the awaited edge means it saw a NACK and stopped.
  always_comb begin
    nack    = 1'b0;
    timeout = (state_reg != IDLE) && (state_reg != DONE) &&
              (timer_reg == TIMEOUT_CYCLES - 24'd1);
    case (state_reg)
      XFER_ADDR, XFER_REG, XFER_DATA, XFER_ADDR_R: nack = bus.m_ready & ~sended_rise;
      XFER_RD:                                     nack = bus.m_ready & ~received_rise;
      default:                                     nack = 1'b0;
    endcase
    fail = timeout | nack;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= IDLE;
      timer_reg         <= '0;
      sended_prev_reg   <= 1'b0;
      received_prev_reg <= 1'b0;
      rw_reg            <= 1'b0;
      dev_reg           <= '0;
      regaddr_reg       <= '0;
      wdata_reg         <= '0;
      cmd_ready_reg     <= 1'b1;
      rsp_valid_reg     <= 1'b0;
      rsp_err_reg       <= 1'b0;
      rsp_rdata_reg     <= '0;
      m_start_reg       <= 1'b0;
      m_send_reg        <= 1'b0;
      m_receive_reg     <= 1'b0;
      m_datasend_reg    <= '0;
    end else begin
      sended_prev_reg   <= bus.m_sended;
      received_prev_reg <= bus.m_received;
      rsp_valid_reg     <= 1'b0;
      rsp_err_reg       <= 1'b0;
      m_start_reg       <= 1'b0;
      if (state_reg != IDLE && timer_reg != 24'hFF_FFFF)
        timer_reg <= timer_reg + 24'd1;

      if (fail) begin
        state_reg     <= IDLE;
        cmd_ready_reg <= 1'b1;
        rsp_valid_reg <= 1'b1;
        rsp_err_reg   <= 1'b1;
        rsp_rdata_reg <= '0;
        m_send_reg    <= 1'b0;
        m_receive_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            state_reg <= IDLE;
            if (accept) begin
              state_reg      <= ADDR_W;
              rw_reg         <= bus.cmd_rw;
              dev_reg        <= bus.cmd_dev;
              regaddr_reg    <= bus.cmd_reg;
              wdata_reg      <= bus.cmd_wdata;
              cmd_ready_reg  <= 1'b0;
              rsp_rdata_reg  <= '0;
              timer_reg      <= '0;
              m_datasend_reg <= {bus.cmd_dev, 1'b0};
              m_start_reg    <= 1'b1;
            end
          end
          ADDR_W: begin
            if (!bus.m_ready) state_reg <= XFER_ADDR;
          end
          XFER_ADDR: begin
            if (sended_rise) begin
              m_datasend_reg <= regaddr_reg;
              m_send_reg     <= 1'b1;
              state_reg      <= XFER_REG;
            end
          end
          XFER_REG: begin
            if (sended_rise) begin
              if (rw_reg) begin
                m_datasend_reg <= {dev_reg, 1'b1};
                m_start_reg    <= 1'b1;
                m_send_reg     <= 1'b0;
                state_reg      <= XFER_ADDR_R;
              end else begin
                m_datasend_reg <= wdata_reg;
                m_send_reg     <= 1'b1;
                state_reg      <= XFER_DATA;
              end
            end else if (sended_fall) begin
              m_send_reg <= 1'b0;
            end
          end
          XFER_DATA: begin
            // Leaving m_send low after the data byte lets the master issue STOP.
            if (sended_rise) begin
              m_send_reg <= 1'b0;
              state_reg  <= WAIT_STOP;
            end else if (sended_fall) begin
              m_send_reg <= 1'b0;
            end
          end
          XFER_ADDR_R: begin
            if (sended_rise) begin
              m_receive_reg <= 1'b1;
              state_reg     <= XFER_RD;
            end
          end
          XFER_RD: begin
            if (received_rise) begin
              rsp_rdata_reg <= bus.m_datareceive;
              m_receive_reg <= 1'b0;
              state_reg     <= WAIT_STOP;
            end else if (sended_fall) begin
              m_receive_reg <= 1'b0;
            end
          end
          WAIT_STOP: begin
            if (bus.m_ready) begin
              state_reg     <= DONE;
              cmd_ready_reg <= 1'b1;
              rsp_valid_reg <= 1'b1;
              m_send_reg    <= 1'b0;
              m_receive_reg <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_err    = rsp_err_reg;
  assign bus.rsp_rdata  = rsp_rdata_reg;
  assign bus.m_start    = m_start_reg;
  assign bus.m_send     = m_send_reg;
  assign bus.m_receive  = m_receive_reg;
  assign bus.m_datasend = m_datasend_reg;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer: the initial block plays the byte master step by step
// and checks the sequencer's strobes, bytes and responses against hand-computed values.
module tb_i2c_reg_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   k;
  logic got;

  i2c_reg_sequencer_if bus ();

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    bus.cmd_rw    = rw;
    bus.cmd_dev   = dev;
    bus.cmd_reg   = rg;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    $display("issue rw=%0d dev=0x%02h reg=0x%02h wdata=0x%02h", rw, dev, rg, wd);
  endtask

  // Strobe exclusivity must hold on every cycle out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("strobe_excl", 32'({bus.m_send & bus.m_receive, bus.m_start & bus.m_send}), 32'h0);
    end
  end

  initial begin
    reset             = 1'b0;
    bus.cmd_valid     = 1'b0;
    bus.cmd_rw        = 1'b0;
    bus.cmd_dev       = '0;
    bus.cmd_reg       = '0;
    bus.cmd_wdata     = '0;
    bus.m_ready       = 1'b1;
    bus.m_sended      = 1'b0;
    bus.m_received    = 1'b0;
    bus.m_datareceive = '0;
    repeat (3) step();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    check("rst_strobes",   32'({bus.m_start, bus.m_send, bus.m_receive}), 32'h0);
    check("rst_datasend",  32'(bus.m_datasend), 32'h0);
    reset = 1'b1;
    step();

    // Command held off while the master is busy
    bus.m_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    repeat (2) step();
    check("holdoff_start", 32'(bus.m_start), 32'h0);
    check("holdoff_ready", 32'(bus.cmd_ready), 32'h1);
    bus.cmd_valid = 1'b0;
    bus.m_ready = 1'b1;
    step();

    // Register write 0x50/0x10 <= 0xA5, all ACKed
    issue(1'b0, 7'h50, 8'h10, 8'hA5);
    check("wr_start", 32'(bus.m_start), 32'h1);
    check("wr_addr_byte", 32'(bus.m_datasend), 32'hA0);
    check("wr_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    bus.m_ready = 1'b0;
    step();
    check("wr_start_pulse", 32'(bus.m_start), 32'h0);
    bus.m_sended = 1'b1;
    step();
    check("wr_reg_send", 32'(bus.m_send), 32'h1);
    check("wr_reg_byte", 32'(bus.m_datasend), 32'h10);
    step();
    check("wr_send_held", 32'(bus.m_send), 32'h1);
    bus.m_sended = 1'b0;
    step();
    check("wr_send_drop", 32'(bus.m_send), 32'h0);
    bus.m_sended = 1'b1;
    step();
    check("wr_data_send", 32'(bus.m_send), 32'h1);
    check("wr_data_byte", 32'(bus.m_datasend), 32'hA5);
    bus.m_sended = 1'b0;
    step();
    check("wr_data_drop", 32'(bus.m_send), 32'h0);
    bus.m_sended = 1'b1;
    step();
    check("wr_no_more_send", 32'(bus.m_send), 32'h0);
    check("wr_not_done", 32'(bus.rsp_valid), 32'h0);
    bus.m_sended = 1'b0;
    bus.m_ready = 1'b1;
    step();
    check("wr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("wr_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    check("wr_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    $display("write done rsp_valid=%0d err=%0d", bus.rsp_valid, bus.rsp_err);
    step();
    check("wr_rsp_pulse", 32'(bus.rsp_valid), 32'h0);

    // Register read 0x68/0x75, slave returns 0x71
    issue(1'b1, 7'h68, 8'h75, 8'h00);
    check("rd_addr_byte", 32'(bus.m_datasend), 32'hD0);
    check("rd_start", 32'(bus.m_start), 32'h1);
    bus.m_ready = 1'b0;
    step();
    bus.m_sended = 1'b1;
    step();
    check("rd_reg_byte", 32'(bus.m_datasend), 32'h75);
    check("rd_reg_send", 32'(bus.m_send), 32'h1);
    bus.m_sended = 1'b0;
    step();
    bus.m_sended = 1'b1;
    step();
    check("rd_sr_start", 32'(bus.m_start), 32'h1);
    check("rd_sr_byte", 32'(bus.m_datasend), 32'hD1);
    check("rd_sr_nosend", 32'(bus.m_send), 32'h0);
    bus.m_sended = 1'b0;
    step();
    check("rd_sr_pulse", 32'(bus.m_start), 32'h0);
    bus.m_sended = 1'b1;
    step();
    check("rd_receive", 32'(bus.m_receive), 32'h1);
    bus.m_sended = 1'b0;
    step();
    check("rd_receive_drop", 32'(bus.m_receive), 32'h0);
    bus.m_datareceive = 8'h71;
    bus.m_received = 1'b1;
    step();
    check("rd_not_done", 32'(bus.rsp_valid), 32'h0);
    bus.m_received = 1'b0;
    bus.m_ready = 1'b1;
    step();
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rd_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'h71);
    $display("read done rdata=0x%02h err=%0d", bus.rsp_rdata, bus.rsp_err);
    step();

    // Write to absent device 0x3C: address NACK, master stops
    issue(1'b0, 7'h3C, 8'h01, 8'h02);
    check("nack_addr_byte", 32'(bus.m_datasend), 32'h78);
    bus.m_ready = 1'b0;
    step();
    bus.m_sended = 1'b1;
    step();
    bus.m_sended = 1'b0;
    bus.m_ready = 1'b1;
    step();
    check("nack_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("nack_rsp_err", 32'(bus.rsp_err), 32'h1);
    check("nack_strobes", 32'({bus.m_start, bus.m_send, bus.m_receive}), 32'h0);
    check("nack_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    $display("absent device rsp_err=%0d", bus.rsp_err);
    step();

    // Read where the slave NACKs the register byte
    issue(1'b1, 7'h68, 8'h75, 8'h00);
    check("rnack_rdata_clr", 32'(bus.rsp_rdata), 32'h0);
    bus.m_ready = 1'b0;
    step();
    bus.m_sended = 1'b1;
    step();
    bus.m_sended = 1'b0;
    step();
    bus.m_sended = 1'b1;
    step();
    bus.m_sended = 1'b0;
    bus.m_ready = 1'b1;
    step();
    check("rnack_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rnack_rsp_err", 32'(bus.rsp_err), 32'h1);
    check("rnack_rdata", 32'(bus.rsp_rdata), 32'h0);
    check("rnack_strobes", 32'({bus.m_start, bus.m_send, bus.m_receive}), 32'h0);
    $display("reg NACK rsp_err=%0d rdata=0x%02h", bus.rsp_err, bus.rsp_rdata);
    step();

    // Timeout: master stuck (SCL held low), response expected 100 cycles after accept
    issue(1'b0, 7'h22, 8'h33, 8'h44);
    bus.m_ready = 1'b0;
    k = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      step();
      k++;
      if (bus.rsp_valid) got = 1'b1;
    end
    check("tmo_cycle", 32'(k), 32'd100);
    check("tmo_rsp_err", 32'(bus.rsp_err), 32'h1);
    check("tmo_strobes", 32'({bus.m_start, bus.m_send, bus.m_receive}), 32'h0);
    check("tmo_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    $display("timeout after %0d cycles err=%0d", k, bus.rsp_err);
    bus.m_ready = 1'b1;
    step();
    check("tmo_rsp_pulse", 32'(bus.rsp_valid), 32'h0);

    // Reset during XFER_REG drops the command silently
    issue(1'b0, 7'h50, 8'h20, 8'h5A);
    bus.m_ready = 1'b0;
    step();
    bus.m_sended = 1'b1;
    step();
    check("rstmid_send", 32'(bus.m_send), 32'h1);
    reset = 1'b0;
    bus.m_sended = 1'b0;
    bus.m_ready = 1'b1;
    step();
    check("rstmid_strobes", 32'({bus.m_start, bus.m_send, bus.m_receive}), 32'h0);
    check("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    $display("reset mid-command cmd_ready=%0d", bus.cmd_ready);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
